// File: rtl/lcd_rgb_rx.sv
// lcd_rgb_rx: parallel RGB565 receiver (DE/HS/VS/RGB). It registers the
// raw port, rebuilds a pixel stream with x/y coordinates, measures the
// active resolution of every frame and reports lock once consecutive
// frames agree. Line boundaries come from DE edges only. HS is registered
// and polarity-normalised but does not drive any logic.
module lcd_rgb_rx #(
  parameter logic HS_ACT      = 1'b0,
  parameter logic VS_ACT      = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic        lcd_de,
  input  logic        lcd_hs,
  input  logic        lcd_vs,
  input  logic [15:0] lcd_rgb,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        frame_start,
  output logic        line_end,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        locked,
  output logic        frame_err
);

  localparam logic [10:0] XY_MAX = 11'd2047;
  localparam logic [3:0]  CNT_MAX = 4'd15;
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  // input stage
  logic        de_d;
  logic        hs_d;
  logic        vs_d;
  logic [15:0] rgb_d;

  // frame tracking state
  logic        synced;
  logic        vs_act_q;
  logic [10:0] x;
  logic [10:0] y;
  logic [10:0] line_w;
  logic        have_line;
  logic        line_act;
  logic        ovf;
  logic        incons;
  logic [3:0]  match_cnt;

  // combinational helpers
  logic        vs_act;
  logic        hs_act_unused;
  logic        vs_rise;
  logic        accept;
  logic        line_done;
  logic [10:0] x_inc;
  logic [10:0] y_inc;
  logic        ovf_nxt;
  logic        incons_nxt;
  logic [10:0] frame_h;
  logic [10:0] frame_v;
  logic        frame_ok;
  logic        same_dims;
  logic [3:0]  match_nxt;

  assign vs_act        = (vs_d == VS_ACT);
  assign hs_act_unused = (hs_d == HS_ACT);

  // Register every raw input; reset parks the syncs at their idle level so
  // that leaving reset never looks like a VS edge.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      de_d  <= 1'b0;
      hs_d  <= ~HS_ACT;
      vs_d  <= ~VS_ACT;
      rgb_d <= '0;
    end else begin
      de_d  <= lcd_de;
      hs_d  <= lcd_hs;
      vs_d  <= lcd_vs;
      rgb_d <= lcd_rgb;
    end
  end

  // Edge detection and the frame verdict, including a line that completes
  // in the very cycle VS rises.
  always_comb begin
    vs_rise    = vs_act & ~vs_act_q;
    accept     = synced & de_d & ~vs_act;
    line_done  = line_act & ~de_d;
    x_inc      = (x == XY_MAX) ? x : x + 11'd1;
    y_inc      = (y == XY_MAX) ? y : y + 11'd1;
    ovf_nxt    = ovf | (accept & (x == XY_MAX)) | (line_done & (y == XY_MAX));
    incons_nxt = incons | (de_d & vs_act) | (line_done & have_line & (x != line_w));
    frame_h    = have_line ? line_w : x;
    frame_v    = y + {10'd0, line_done};
    frame_ok   = (have_line | line_done) & ~ovf_nxt & ~incons_nxt;
    same_dims  = (frame_h == h_disp) && (frame_v == v_disp);
    match_nxt  = 4'd0;
    if (frame_ok) begin
      if (same_dims) match_nxt = (match_cnt == CNT_MAX) ? CNT_MAX : match_cnt + 4'd1;
      else           match_nxt = 4'd1;
    end
  end

  // Pixel stream, line accounting and per-frame evaluation.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      synced      <= 1'b0;
      vs_act_q    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_w      <= '0;
      have_line   <= 1'b0;
      line_act    <= 1'b0;
      ovf         <= 1'b0;
      incons      <= 1'b0;
      match_cnt   <= '0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      h_disp      <= '0;
      v_disp      <= '0;
      locked      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      vs_act_q    <= vs_act;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_err   <= 1'b0;
      if (!synced) begin
        if (vs_rise) begin
          synced      <= 1'b1;
          frame_start <= 1'b1;
        end
      end else begin
        if (accept) begin
          pixel_valid <= 1'b1;
          pixel_data  <= rgb_d;
          pixel_xpos  <= x;
          pixel_ypos  <= y;
          x           <= x_inc;
          line_act    <= 1'b1;
        end
        if (line_done) begin
          line_end  <= 1'b1;
          x         <= '0;
          line_act  <= 1'b0;
          y         <= y_inc;
          have_line <= 1'b1;
          if (!have_line) line_w <= x;
        end
        ovf    <= ovf_nxt;
        incons <= incons_nxt;
        if (vs_rise) begin
          frame_start <= 1'b1;
          match_cnt   <= match_nxt;
          locked      <= (match_nxt >= LOCK_N);
          if (frame_ok) begin
            h_disp <= frame_h;
            v_disp <= frame_v;
          end else begin
            frame_err <= 1'b1;
          end
          x         <= '0;
          y         <= '0;
          line_w    <= '0;
          have_line <= 1'b0;
          line_act  <= 1'b0;
          ovf       <= 1'b0;
          incons    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed testbench for lcd_rgb_rx: 800-wide x 3-line frames, lock/unlock,
// pixel latency and data, reset behaviour, x saturation, back-to-back lines.
module tb_lcd_rgb_rx;
  logic        lcd_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        lcd_de = 1'b0;
  logic        lcd_hs = 1'b1;
  logic        lcd_vs = 1'b1;
  logic [15:0] lcd_rgb = '0;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        frame_start;
  logic        line_end;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic        locked;
  logic        frame_err;

  int checks = 0;
  int failures = 0;

  int fs_cnt = 0;
  int err_cnt = 0;
  int pv_cnt = 0;
  int le_cnt = 0;
  logic        fs_err = 1'b0;
  logic        fs_locked = 1'b0;
  logic [10:0] fs_h = '0;
  logic [10:0] fs_v = '0;
  logic [10:0] last_x = '0;

  lcd_rgb_rx #(.HS_ACT(1'b0), .VS_ACT(1'b0), .LOCK_FRAMES(2)) dut (
    .lcd_pclk(lcd_pclk), .rst(rst), .lcd_de(lcd_de), .lcd_hs(lcd_hs),
    .lcd_vs(lcd_vs), .lcd_rgb(lcd_rgb), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start), .line_end(line_end), .h_disp(h_disp),
    .v_disp(v_disp), .locked(locked), .frame_err(frame_err)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  // event recorder, sampled away from the active edge
  always @(negedge lcd_pclk) begin
    if (frame_start) begin
      fs_cnt++;
      fs_err = frame_err;
      fs_locked = locked;
      fs_h = h_disp;
      fs_v = v_disp;
    end
    if (frame_err) err_cnt++;
    if (pixel_valid) begin
      pv_cnt++;
      last_x = pixel_xpos;
    end
    if (line_end) le_cnt++;
  end

  function automatic logic [15:0] pat(int i, int w);
    if (i == 0) return 16'hF800;
    if (i == w - 1) return 16'h001F;
    return 16'(i * 3 + 1);
  endfunction

  task automatic tick();
    @(negedge lcd_pclk);
  endtask

  task automatic vs_pulse();
    lcd_de = 1'b0;
    lcd_vs = 1'b0;
    tick(); tick();
    lcd_vs = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic drive_line(int w, int gap);
    for (int i = 0; i < w; i++) begin
      lcd_de = 1'b1;
      lcd_rgb = pat(i, w);
      tick();
    end
    lcd_de = 1'b0;
    for (int g = 0; g < gap; g++) begin
      lcd_hs = (g == 0) ? 1'b0 : 1'b1;
      tick();
    end
    lcd_hs = 1'b1;
  endtask

  task automatic drive_frame(int w, int h, int bad);
    for (int l = 0; l < h; l++) drive_line((l == bad) ? w - 1 : w, 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("FAIL reset_pixel_valid got=%0b exp=0", pixel_valid); end
    checks++; if (pixel_data !== 16'h0) begin failures++; $display("FAIL reset_pixel_data got=%h exp=0", pixel_data); end
    checks++; if (pixel_xpos !== 11'd0) begin failures++; $display("FAIL reset_xpos got=%0d exp=0", pixel_xpos); end
    checks++; if (pixel_ypos !== 11'd0) begin failures++; $display("FAIL reset_ypos got=%0d exp=0", pixel_ypos); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start got=%0b exp=0", frame_start); end
    checks++; if (line_end !== 1'b0) begin failures++; $display("FAIL reset_line_end got=%0b exp=0", line_end); end
    checks++; if (h_disp !== 11'd0) begin failures++; $display("FAIL reset_h_disp got=%0d exp=0", h_disp); end
    checks++; if (v_disp !== 11'd0) begin failures++; $display("FAIL reset_v_disp got=%0d exp=0", v_disp); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
    rst = 1'b0;
    repeat (4) tick();
    checks++; if (fs_cnt !== 0) begin failures++; $display("FAIL reset_no_false_vs got=%0d exp=0", fs_cnt); end
  endtask

  // 3 frames of 800x3: initial VS plus 3 evaluations
  task automatic test_lock();
    int f0, p0, l0;
    f0 = fs_cnt;
    vs_pulse();
    checks++; if (fs_cnt - f0 !== 1) begin failures++; $display("FAIL lock_fs1_count got=%0d exp=1", fs_cnt - f0); end
    checks++; if (fs_err !== 1'b0) begin failures++; $display("FAIL lock_fs1_err got=%0b exp=0", fs_err); end
    checks++; if (fs_h !== 11'd0) begin failures++; $display("FAIL lock_fs1_h got=%0d exp=0", fs_h); end
    for (int f = 2; f <= 4; f++) begin
      p0 = pv_cnt; l0 = le_cnt;
      drive_frame(800, 3, -1);
      vs_pulse();
      checks++; if (fs_cnt - f0 !== f) begin failures++; $display("FAIL lock_fs_count got=%0d exp=%0d", fs_cnt - f0, f); end
      checks++; if (pv_cnt - p0 !== 2400) begin failures++; $display("FAIL lock_pixels got=%0d exp=2400", pv_cnt - p0); end
      checks++; if (le_cnt - l0 !== 3) begin failures++; $display("FAIL lock_line_ends got=%0d exp=3", le_cnt - l0); end
      checks++; if (fs_h !== 11'd800) begin failures++; $display("FAIL lock_h_disp got=%0d exp=800", fs_h); end
      checks++; if (fs_v !== 11'd3) begin failures++; $display("FAIL lock_v_disp got=%0d exp=3", fs_v); end
      checks++; if (fs_err !== 1'b0) begin failures++; $display("FAIL lock_err got=%0b exp=0", fs_err); end
      checks++; if (fs_locked !== (f >= 3)) begin failures++; $display("FAIL lock_locked f=%0d got=%0b exp=%0b", f, fs_locked, f >= 3); end
    end
  endtask

  // first two lines of frame 4 with cycle-exact checks
  task automatic test_pixel_line();
    int w = 800;
    logic exp_v;
    for (int t = 0; t <= w + 2; t++) begin
      exp_v = (t >= 2 && t <= w + 1);
      checks++; if (pixel_valid !== exp_v) begin failures++; $display("FAIL px_valid t=%0d got=%0b exp=%0b", t, pixel_valid, exp_v); end
      checks++; if (line_end !== (t == w + 2)) begin failures++; $display("FAIL px_line_end t=%0d got=%0b exp=%0b", t, line_end, t == w + 2); end
      if (t == 2 || t == w + 1) begin
        checks++; if (pixel_xpos !== 11'(t - 2)) begin failures++; $display("FAIL px_xpos t=%0d got=%0d exp=%0d", t, pixel_xpos, t - 2); end
        checks++; if (pixel_data !== ((t == 2) ? 16'hF800 : 16'h001F)) begin failures++; $display("FAIL px_data t=%0d got=%h", t, pixel_data); end
        checks++; if (pixel_ypos !== 11'd0) begin failures++; $display("FAIL px_ypos0 got=%0d exp=0", pixel_ypos); end
      end
      if (t < w) begin lcd_de = 1'b1; lcd_rgb = pat(t, w); end
      else begin lcd_de = 1'b0; lcd_hs = (t == w) ? 1'b0 : 1'b1; end
      tick();
    end
    lcd_hs = 1'b1;
    for (int t = 0; t < w + 2; t++) begin
      if (t == 2) begin
        checks++; if (pixel_valid !== 1'b1 || pixel_ypos !== 11'd1 || pixel_xpos !== 11'd0)
          begin failures++; $display("FAIL px_line2 valid=%0b ypos=%0d xpos=%0d exp 1/1/0", pixel_valid, pixel_ypos, pixel_xpos); end
      end
      lcd_de = (t < w);
      lcd_rgb = pat(t, w);
      tick();
    end
  endtask

  // short third line in frame 4, then recovery
  task automatic test_short_line();
    int e0 = err_cnt;
    drive_line(799, 2);
    vs_pulse();
    checks++; if (fs_err !== 1'b1) begin failures++; $display("FAIL short_err got=%0b exp=1", fs_err); end
    checks++; if (fs_locked !== 1'b0) begin failures++; $display("FAIL short_locked got=%0b exp=0", fs_locked); end
    checks++; if (fs_h !== 11'd800) begin failures++; $display("FAIL short_h_held got=%0d exp=800", fs_h); end
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL short_err_pulses got=%0d exp=1", err_cnt - e0); end
    drive_frame(800, 3, -1);
    vs_pulse();
    checks++; if (fs_locked !== 1'b0 || fs_err !== 1'b0) begin failures++; $display("FAIL recover1 locked=%0b err=%0b exp 0/0", fs_locked, fs_err); end
    drive_frame(800, 3, -1);
    vs_pulse();
    checks++; if (fs_locked !== 1'b1 || fs_err !== 1'b0) begin failures++; $display("FAIL recover2 locked=%0b err=%0b exp 1/0", fs_locked, fs_err); end
  endtask

  task automatic test_rst_mid_line();
    int p0, e0, f0;
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL midrst_pre_locked got=%0b exp=1", locked); end
    e0 = err_cnt;
    p0 = pv_cnt;
    for (int i = 0; i < 300; i++) begin
      lcd_de = 1'b1;
      lcd_rgb = pat(i, 300);
      if (i == 100) rst = 1'b1;
      tick();
      if (i == 100) begin
        checks++;
        if ({pixel_valid, pixel_data, pixel_xpos, pixel_ypos, frame_start, line_end, h_disp, v_disp, locked, frame_err} !== 65'd0) begin
          failures++;
          $display("FAIL midrst_outputs got=%h exp=0", {pixel_valid, pixel_data, pixel_xpos, pixel_ypos, frame_start, line_end, h_disp, v_disp, locked, frame_err});
        end
        rst = 1'b0;
        p0 = pv_cnt;
      end
    end
    lcd_de = 1'b0;
    tick(); tick();
    drive_line(20, 2);
    checks++; if (pv_cnt - p0 !== 0) begin failures++; $display("FAIL midrst_ignored got=%0d exp=0", pv_cnt - p0); end
    f0 = fs_cnt;
    vs_pulse();
    checks++; if (fs_cnt - f0 !== 1 || fs_err !== 1'b0 || err_cnt != e0) begin failures++; $display("FAIL midrst_vs fs=%0d err=%0b exp 1/0", fs_cnt - f0, fs_err); end
    checks++; if (fs_locked !== 1'b0 || fs_h !== 11'd0) begin failures++; $display("FAIL midrst_state locked=%0b h=%0d exp 0/0", fs_locked, fs_h); end
    p0 = pv_cnt;
    drive_line(20, 2);
    checks++; if (pv_cnt - p0 !== 20) begin failures++; $display("FAIL midrst_resume got=%0d exp=20", pv_cnt - p0); end
  endtask

  task automatic test_rst_mid_frame();
    int p0, l0, e0, f0;
    rst = 1'b1;
    lcd_de = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    p0 = pv_cnt; l0 = le_cnt; e0 = err_cnt;
    for (int i = 0; i < 42; i++) begin
      lcd_de = ((i % 7) < 5);
      lcd_rgb = 16'(i);
      tick();
    end
    lcd_de = 1'b0;
    tick(); tick();
    checks++; if (pv_cnt - p0 !== 0) begin failures++; $display("FAIL midframe_no_pixels got=%0d exp=0", pv_cnt - p0); end
    checks++; if (le_cnt - l0 !== 0) begin failures++; $display("FAIL midframe_no_line_end got=%0d exp=0", le_cnt - l0); end
    f0 = fs_cnt;
    vs_pulse();
    checks++; if (fs_cnt - f0 !== 1) begin failures++; $display("FAIL midframe_vs got=%0d exp=1", fs_cnt - f0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL midframe_err got=%0d exp=0", err_cnt - e0); end
    p0 = pv_cnt;
    drive_line(10, 2);
    checks++; if (pv_cnt - p0 !== 10) begin failures++; $display("FAIL midframe_resume got=%0d exp=10", pv_cnt - p0); end
  endtask

  task automatic test_overflow();
    int p0, e0;
    p0 = pv_cnt; e0 = err_cnt;
    for (int t = 0; t < 2100; t++) begin
      if (t == 2080) begin
        checks++; if (pixel_valid !== 1'b1 || pixel_xpos !== 11'd2047) begin failures++; $display("FAIL ovf_hold valid=%0b xpos=%0d exp 1/2047", pixel_valid, pixel_xpos); end
      end
      lcd_de = 1'b1;
      lcd_rgb = 16'(t);
      tick();
    end
    lcd_de = 1'b0;
    tick(); tick(); tick();
    checks++; if (last_x !== 11'd2047) begin failures++; $display("FAIL ovf_last_x got=%0d exp=2047", last_x); end
    checks++; if (pv_cnt - p0 !== 2100) begin failures++; $display("FAIL ovf_pixels got=%0d exp=2100", pv_cnt - p0); end
    vs_pulse();
    checks++; if (fs_err !== 1'b1 || err_cnt - e0 !== 1) begin failures++; $display("FAIL ovf_err got=%0b pulses=%0d exp 1/1", fs_err, err_cnt - e0); end
  endtask

  // 16x3 frames, single-cycle DE gaps, last line ends in the VS cycle
  task automatic test_back_to_back();
    int l0;
    for (int f = 0; f < 2; f++) begin
      l0 = le_cnt;
      for (int l = 0; l < 3; l++) begin
        for (int i = 0; i < 16; i++) begin
          lcd_de = 1'b1;
          lcd_rgb = pat(i, 16);
          tick();
        end
        if (l < 2) begin
          lcd_de = 1'b0;
          tick();
        end
      end
      vs_pulse();
      checks++; if (fs_err !== 1'b0) begin failures++; $display("FAIL b2b_err f=%0d got=%0b exp=0", f, fs_err); end
      checks++; if (fs_h !== 11'd16 || fs_v !== 11'd3) begin failures++; $display("FAIL b2b_dims f=%0d got=%0dx%0d exp=16x3", f, fs_h, fs_v); end
      checks++; if (fs_locked !== (f == 1)) begin failures++; $display("FAIL b2b_locked f=%0d got=%0b exp=%0b", f, fs_locked, f == 1); end
      checks++; if (le_cnt - l0 !== 3) begin failures++; $display("FAIL b2b_line_ends f=%0d got=%0d exp=3", f, le_cnt - l0); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel_line();
    test_short_line();
    test_rst_mid_line();
    test_rst_mid_frame();
    test_overflow();
    test_back_to_back();
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
